// File: rtl/mod_frame_sched.sv
// mod_frame_sched: preamble/payload/guard symbol scheduler driving the All_mod select/bit_in inputs.
// Build option: define MOD_FRAME_SCHED_CRC_EN to append a CRC-8 (poly 0x07) byte after the payload.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no frame; waits for start with a non-zero frame_len
// S_PRE   | alternating 1,0 preamble symbols on BPSK
// S_PAY   | payload bytes sliced MSB-first; zero symbol + underrun if FIFO empty
// S_CRC   | CRC byte sliced like payload (only with MOD_FRAME_SCHED_CRC_EN)
// S_GUARD | zero guard symbols in the latched scheme
module mod_frame_sched #(
  parameter int SYM_DIV      = 4,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cfg_sel,
  input  logic [7:0] frame_len,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [1:0] mod_sel,
  output logic [3:0] mod_bits,
  output logic       sym_stb,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int DIV_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam int CNT_W = $clog2(PREAMBLE_LEN + GUARD_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_PAY,
`ifdef MOD_FRAME_SCHED_CRC_EN
    S_CRC,
`endif
    S_GUARD
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_scheme;
  logic [7:0]       r_len;
  logic [7:0]       r_bytes;
  logic [7:0]       r_shift;
  logic [2:0]       r_slice;
`ifdef MOD_FRAME_SCHED_CRC_EN
  logic [7:0]       r_crc;
`endif

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_boundary;
  logic             w_fetch;
  logic [7:0]       w_head;

  function automatic logic [2:0] f_bps(input logic [1:0] sch);
    case (sch)
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] f_last(input logic [1:0] sch);
    case (sch)
      2'b01:   return 3'd3;
      2'b10:   return 3'd1;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [3:0] f_top(input logic [7:0] b, input logic [1:0] sch);
    case (sch)
      2'b01:   return {2'b00, b[7:6]};
      2'b10:   return b[7:4];
      default: return {3'b000, b[7]};
    endcase
  endfunction

`ifdef MOD_FRAME_SCHED_CRC_EN
  function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_empty = (r_wr == r_rd);
  assign s_ready = !w_full;
  assign w_push  = s_valid && s_ready;
  assign w_head  = r_mem[r_rd[AW-1:0]];

  // A fetch happens at the boundary that ends the preamble or a completed byte.
  always_comb begin
    w_boundary = (r_state != S_IDLE) && (r_div == DIV_W'(SYM_DIV - 1));
    w_fetch    = w_boundary &&
                 (((r_state == S_PRE) && (r_cnt == CNT_W'(PREAMBLE_LEN))) ||
                  ((r_state == S_PAY) && (r_slice == 3'd0) && (r_bytes != r_len)));
    w_pop      = w_fetch && !w_empty;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_cnt    <= '0;
      r_scheme <= 2'b00;
      r_len    <= 8'd0;
      r_bytes  <= 8'd0;
      r_shift  <= 8'd0;
      r_slice  <= 3'd0;
`ifdef MOD_FRAME_SCHED_CRC_EN
      r_crc    <= 8'd0;
`endif
      mod_sel  <= 2'b00;
      mod_bits <= 4'd0;
      sym_stb  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sym_stb  <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start && (frame_len != 8'd0)) begin
          r_state  <= S_PRE;
          r_scheme <= (cfg_sel == 2'b11) ? 2'b00 : cfg_sel;
          r_len    <= frame_len;
          r_bytes  <= 8'd0;
          r_div    <= '0;
          r_cnt    <= CNT_W'(1);
`ifdef MOD_FRAME_SCHED_CRC_EN
          r_crc    <= 8'd0;
`endif
          mod_sel  <= 2'b00;
          mod_bits <= 4'd1;
          sym_stb  <= 1'b1;
          busy     <= 1'b1;
        end
      end else if (!w_boundary) begin
        r_div <= r_div + 1'b1;
      end else begin
        r_div   <= '0;
        sym_stb <= 1'b1;
        if (w_fetch) begin
          r_state <= S_PAY;
          mod_sel <= r_scheme;
          if (w_empty) begin
            mod_bits <= 4'd0;
            underrun <= 1'b1;
            r_slice  <= 3'd0;
          end else begin
            mod_bits <= f_top(w_head, r_scheme);
            r_shift  <= w_head << f_bps(r_scheme);
            r_slice  <= f_last(r_scheme);
            r_bytes  <= r_bytes + 8'd1;
`ifdef MOD_FRAME_SCHED_CRC_EN
            r_crc    <= f_crc8(r_crc, w_head);
`endif
          end
        end else begin
          case (r_state)
            S_PRE: begin
              mod_bits <= {3'b000, ~r_cnt[0]};
              r_cnt    <= r_cnt + 1'b1;
            end
            S_PAY: begin
              if (r_slice != 3'd0) begin
                mod_bits <= f_top(r_shift, r_scheme);
                r_shift  <= r_shift << f_bps(r_scheme);
                r_slice  <= r_slice - 1'b1;
              end else begin
`ifdef MOD_FRAME_SCHED_CRC_EN
                r_state  <= S_CRC;
                mod_bits <= f_top(r_crc, r_scheme);
                r_shift  <= r_crc << f_bps(r_scheme);
                r_slice  <= f_last(r_scheme);
`else
                r_state  <= S_GUARD;
                mod_bits <= 4'd0;
                r_cnt    <= CNT_W'(1);
`endif
              end
            end
`ifdef MOD_FRAME_SCHED_CRC_EN
            S_CRC: begin
              if (r_slice != 3'd0) begin
                mod_bits <= f_top(r_shift, r_scheme);
                r_shift  <= r_shift << f_bps(r_scheme);
                r_slice  <= r_slice - 1'b1;
              end else begin
                r_state  <= S_GUARD;
                mod_bits <= 4'd0;
                r_cnt    <= CNT_W'(1);
              end
            end
`endif
            S_GUARD: begin
              if (r_cnt != CNT_W'(GUARD_LEN)) begin
                mod_bits <= 4'd0;
                r_cnt    <= r_cnt + 1'b1;
              end else begin
                r_state  <= S_IDLE;
                mod_sel  <= 2'b00;
                mod_bits <= 4'd0;
                sym_stb  <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_frame_sched.sv
// Bench for mod_frame_sched: directed and random frames against a symbol-list reference model.
// Expects CRC symbols only when MOD_FRAME_SCHED_CRC_EN is defined for the build.
module tb_mod_frame_sched;
  localparam int SYM_DIV = 4;
  localparam int PRE     = 8;
  localparam int GUARD   = 2;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cfg_sel = 2'b00;
  logic [7:0] frame_len = 8'd0;
  logic [7:0] s_data = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [1:0] mod_sel;
  logic [3:0] mod_bits;
  logic       sym_stb;
  logic       busy;
  logic       done;
  logic       underrun;

  mod_frame_sched #(
    .SYM_DIV(SYM_DIV), .PREAMBLE_LEN(PRE), .GUARD_LEN(GUARD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_sel(cfg_sel), .frame_len(frame_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .mod_sel(mod_sel),
    .mod_bits(mod_bits), .sym_stb(sym_stb), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples 1 time unit after each rising edge.
  bit mon_en = 1'b0;
  int t0 = 0;
  int obs_bits[$];
  int obs_sel[$];
  int obs_rel[$];
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_rel = -1;
  int ur_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sym_stb) begin
        obs_bits.push_back(int'(mod_bits));
        obs_sel.push_back(int'(mod_sel));
        obs_rel.push_back(cyc - t0);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_rel = cyc - t0;
      end
      if (underrun) ur_cnt++;
    end
  end

  int exp_bits[$];
  int exp_sel[$];

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int bps(input int sch);
    return (sch == 1) ? 2 : (sch == 2) ? 4 : 1;
  endfunction

  function automatic int eff(input int c);
    return (c == 3) ? 0 : c;
  endfunction

  // Bit-serial long division by x^8+x^2+x+1.
  function automatic int crc_ref(input int bytes[$]);
    int c = 0;
    foreach (bytes[j]) begin
      for (int k = 7; k >= 0; k--) begin
        int fb = ((c >> 7) & 1) ^ ((bytes[j] >> k) & 1);
        c = ((c << 1) & 255) ^ (fb ? 7 : 0);
      end
    end
    return c;
  endfunction

  task automatic m_clear();
    exp_bits.delete();
    exp_sel.delete();
  endtask

  task automatic m_pre();
    for (int k = 0; k < PRE; k++) begin
      exp_bits.push_back((k % 2 == 0) ? 1 : 0);
      exp_sel.push_back(0);
    end
  endtask

  task automatic m_byte(input int sch, input int b);
    int n = bps(sch);
    for (int s = 0; s < 8 / n; s++) begin
      exp_bits.push_back((b >> (8 - n * (s + 1))) % (1 << n));
      exp_sel.push_back(sch);
    end
  endtask

  task automatic m_zeros(input int sch, input int n);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(0);
      exp_sel.push_back(sch);
    end
  endtask

  task automatic m_tail(input int sch, input int bytes[$]);
`ifdef MOD_FRAME_SCHED_CRC_EN
    m_byte(sch, crc_ref(bytes));
`else
    if (bytes.size() > 1000) m_byte(sch, crc_ref(bytes));
`endif
    m_zeros(sch, GUARD);
  endtask

  task automatic m_frame(input int sch, input int bytes[$]);
    m_clear();
    m_pre();
    foreach (bytes[i]) m_byte(sch, bytes[i]);
    m_tail(sch, bytes);
  endtask

  task automatic mon_clear();
    obs_bits.delete();
    obs_sel.delete();
    obs_rel.delete();
    busy_cnt = 0;
    done_cnt = 0;
    done_rel = -1;
    ur_cnt = 0;
  endtask

  task automatic push(input int b);
    @(negedge clk);
    s_data = 8'(b);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic kick(input int cfg, input int len);
    @(negedge clk);
    mon_clear();
    start = 1'b1;
    cfg_sel = 2'(cfg);
    frame_len = 8'(len);
    t0 = cyc;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_sel = 2'($urandom);
    frame_len = 8'($urandom);
  endtask

  task automatic verify(input string name, input int exp_ur);
    int n = exp_bits.size();
    check({name, " nsym"}, obs_bits.size(), n);
    for (int i = 0; i < n && i < obs_bits.size(); i++) begin
      check($sformatf("%s bits[%0d]", name, i), obs_bits[i], exp_bits[i]);
      check($sformatf("%s sel[%0d]", name, i), obs_sel[i], exp_sel[i]);
      check($sformatf("%s stb_cyc[%0d]", name, i), obs_rel[i], 1 + i * SYM_DIV);
    end
    check({name, " done_cyc"}, done_rel, 1 + n * SYM_DIV);
    check({name, " done_cnt"}, done_cnt, 1);
    check({name, " busy_cycles"}, busy_cnt, n * SYM_DIV);
    check({name, " underruns"}, ur_cnt, exp_ur);
  endtask

  task automatic run_frame(input string name, input int cfg, input int len, input bit inject);
    bit got_done = 1'b0;
    kick(cfg, len);
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge clk);
      if (inject && i == 30) begin
        start = 1'b1;
        cfg_sel = 2'b10;
        frame_len = 8'd5;
      end else begin
        start = 1'b0;
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check({name, " done_seen"}, int'(got_done), 1);
    verify(name, 0);
  endtask

  initial begin
    int bq[$];
    int ur_seen;
    bit got_done;

    repeat (3) @(negedge clk);
    check("rst mod_sel", int'(mod_sel), 0);
    check("rst mod_bits", int'(mod_bits), 0);
    check("rst sym_stb", int'(sym_stb), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst underrun", int'(underrun), 0);
    check("rst s_ready", int'(s_ready), 1);
    rst_n = 1'b1;

    // start with frame_len=0 must be ignored
    @(negedge clk);
    start = 1'b1; frame_len = 8'd0; cfg_sel = 2'b01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("len0 busy", int'(busy), 0);
    check("len0 sym_stb", int'(sym_stb), 0);

    push(8'hB4);
    bq = {8'hB4};
    m_frame(1, bq);
    run_frame("qpsk_b4", 1, 1, 1'b0);

    push(8'h81);
    bq = {8'h81};
    m_frame(0, bq);
    run_frame("bpsk_81", 0, 1, 1'b0);

    push(8'h81);
    run_frame("bpsk_cfg11", 3, 1, 1'b0);

    push(8'h3C);
    push(8'hA5);
    push(8'h12);
    check("fifo 3 ready", int'(s_ready), 1);
    push(8'h34);
    check("fifo full ready", int'(s_ready), 0);
    bq = {8'h3C, 8'hA5};
    m_frame(2, bq);
    run_frame("qam16", 2, 2, 1'b0);
    check("fifo drained ready", int'(s_ready), 1);

    bq = {8'h12, 8'h34};
    m_frame(1, bq);
    run_frame("busy_start", 1, 2, 1'b1);

    // underrun: only one byte present, second pushed after three empty slots
    push(8'h0F);
    m_clear();
    m_pre();
    m_byte(1, 8'h0F);
    m_zeros(1, 3);
    m_byte(1, 8'hF0);
    bq = {8'h0F, 8'hF0};
    m_tail(1, bq);
    kick(1, 2);
    ur_seen = 0;
    got_done = 1'b0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (underrun && ur_seen < 3) begin
        ur_seen++;
        if (ur_seen == 3) begin
          s_data = 8'hF0;
          s_valid = 1'b1;
        end
      end
      if (done) got_done = 1'b1;
    end
    s_valid = 1'b0;
    check("underrun done_seen", int'(got_done), 1);
    verify("underrun", 3);

    push(8'h01);
    bq = {8'h01};
    m_frame(1, bq);
    run_frame("crc_01", 1, 1, 1'b0);

    for (int f = 0; f < 6; f++) begin
      int c = int'($urandom_range(0, 3));
      int l = int'($urandom_range(1, DEPTH));
      bq.delete();
      for (int j = 0; j < l; j++) begin
        int b = int'($urandom_range(0, 255));
        bq.push_back(b);
        push(b);
      end
      m_frame(eff(c), bq);
      run_frame($sformatf("rand%0d", f), c, l, 1'b0);
    end

    // reset mid-payload: first byte popped, second left in the FIFO
    push(8'hAA);
    push(8'h55);
    kick(1, 2);
    repeat (40) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst mod_sel", int'(mod_sel), 0);
    check("midrst mod_bits", int'(mod_bits), 0);
    check("midrst sym_stb", int'(sym_stb), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst underrun", int'(underrun), 0);
    check("midrst s_ready", int'(s_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst busy_after", int'(busy), 0);
    check("midrst no_done", done_cnt, 0);

    push(8'h3C);
    bq = {8'h3C};
    m_frame(0, bq);
    run_frame("post_rst", 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
